// File: rtl/ga_pkg.sv
// Shared types, constants and helpers for the genetic-algorithm engine.
`ifndef GA_PKG_MACROS
`define GA_PKG_MACROS
`define GA_GENE_T(W) logic [(W)-1:0]
`define GA_CHROM_T(W, L) logic [(L)-1:0][(W)-1:0]
`endif

package ga_pkg;

  typedef enum logic [3:0] {
    StIdle, StInit, StEval, StSelect, StCross, StMutate, StReplace, StCheck, StDone
  } ga_state_e;

  localparam logic [31:0] LfsrMask    = 32'h8020_0003;
  localparam logic [31:0] DefaultSeed = 32'hACE1_2357;
  // Widest chromosome the match counter supports.
  localparam int unsigned MaxLen      = 64;

  // One right-shift Galois step.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LfsrMask) : (s >> 1);
  endfunction

  // Number of set bits in a per-gene match vector.
  function automatic int unsigned match_count(input logic [MaxLen-1:0] m);
    int unsigned n;
    n = 0;
    for (int k = 0; k < MaxLen; k++) n += 32'(m[k]);
    return n;
  endfunction

  function automatic logic [6:0] fit_percent(input int unsigned fit, input int unsigned len);
    return 7'((fit * 100) / len);
  endfunction

endpackage

// File: rtl/ga_lfsr.sv
// 32-bit Galois LFSR with synchronous load and optional double step.
module ga_lfsr import ga_pkg::*; #(
  parameter int unsigned LoW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [31:0]   seed,
  input  logic          en,
  input  logic          dbl,
  output logic [31:0]   value,
  output logic [7:0]    peek_hi,
  output logic [LoW-1:0] peek_lo
);

  logic [31:0] lfsr_q;
  logic [31:0] step1;

  assign step1   = lfsr_step(lfsr_q);
  assign value   = lfsr_q;
  assign peek_hi = step1[31:24];
  assign peek_lo = step1[LoW-1:0];

  // Load has priority; dbl advances two steps so two draws fit in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= seed;
    end else if (load) begin
      lfsr_q <= seed;
    end else if (en) begin
      lfsr_q <= dbl ? lfsr_step(step1) : step1;
    end
  end

endmodule

// File: rtl/ga_engine.sv
// Genetic-algorithm search engine: init, evaluate, then select/cross/mutate/replace per generation.
module ga_engine import ga_pkg::*; #(
  parameter int unsigned POP    = 8,
  parameter int unsigned LEN    = 12,
  parameter int unsigned GENE_W = 8,
  parameter logic [31:0] SEED   = DefaultSeed,
  localparam int unsigned FW    = $clog2(LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN*GENE_W-1:0]   target_i,
  input  logic [7:0]              mut_thresh,
  input  logic [15:0]             max_gen,
  output logic                    busy,
  output logic                    done,
  output logic                    success,
  output logic [LEN*GENE_W-1:0]   best_o,
  output logic [FW-1:0]           best_fit,
  output logic [6:0]              fitness_percent,
  output logic [15:0]             gen_count
);

  localparam int unsigned IW = $clog2(POP);
  localparam int unsigned GW = (LEN > 2) ? $clog2(LEN) : 1;

  typedef `GA_GENE_T(GENE_W) gene_t;
  typedef `GA_CHROM_T(GENE_W, LEN) chrom_t;

  ga_state_e state_q, state_d;

  logic [IW-1:0] ind_q, p0_q, p1_q, worst_q, wi, max_i;
  logic [GW-1:0] gene_q;
  logic          side_q, p1_vld_q, success_q;
  logic [FW-1:0] f0_q, f1_q, worst_f_q, best_fit_q, wf, max_f, new_best_fit;
  logic [FW-1:0] eval_fit, cur_fit, c0_fit, c1_fit, child_fit;
  logic [7:0]    thresh_q, mb1;
  logic [15:0]   max_gen_q, gen_q, gen_inc;
  logic [31:0]   lfsr_val, cut;
  gene_t         rg1;
  chrom_t        target_q, best_q, child0_q, child1_q;
  chrom_t        pop_q [POP];
  logic [FW-1:0] fit_q [POP];
  logic          start_ok, last_ind, last_gene, mutating;

  function automatic logic [FW-1:0] fit_of(input chrom_t c, input chrom_t t);
    logic [MaxLen-1:0] m;
    m = '0;
    for (int k = 0; k < LEN; k++) m[k] = (c[k] == t[k]);
    return FW'(match_count(m));
  endfunction

  assign busy      = !(state_q == StIdle || state_q == StDone);
  assign done      = (state_q == StDone);
  assign start_ok  = start && !busy;
  assign last_ind  = (ind_q == IW'(POP - 1));
  assign last_gene = (gene_q == GW'(LEN - 1));
  assign mutating  = (state_q == StMutate);

  assign success         = success_q;
  assign best_o          = best_q;
  assign best_fit        = best_fit_q;
  assign gen_count       = gen_q;
  assign fitness_percent = fit_percent(32'(best_fit_q), LEN);

  ga_lfsr #(.LoW(GENE_W)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (start_ok),
    .seed    (SEED),
    .en      (busy),
    .dbl     (mutating),
    .value   (lfsr_val),
    .peek_hi (mb1),
    .peek_lo (rg1)
  );

  assign eval_fit  = fit_of(pop_q[ind_q], target_q);
  assign cur_fit   = fit_q[ind_q];
  assign c0_fit    = fit_of(child0_q, target_q);
  assign c1_fit    = fit_of(child1_q, target_q);
  assign child_fit = side_q ? c1_fit : c0_fit;
  assign cut       = 32'd1 + (lfsr_val % 32'(LEN - 1));
  assign gen_inc   = (gen_q == 16'hFFFF) ? gen_q : gen_q + 16'd1;
  assign new_best_fit = (max_f > best_fit_q) ? max_f : best_fit_q;

  // Running worst of the replace scan, including the individual under the cursor.
  always_comb begin
    wi = worst_q;
    wf = worst_f_q;
    if (ind_q == '0 || cur_fit < worst_f_q) begin
      wi = ind_q;
      wf = cur_fit;
    end
  end

  // Population maximum; strict compare keeps the lowest index on ties.
  always_comb begin
    max_i = '0;
    max_f = fit_q[0];
    for (int i = 1; i < POP; i++) begin
      if (fit_q[i] > max_f) begin
        max_i = IW'(i);
        max_f = fit_q[i];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start_ok) state_d = StInit;
      StInit:         if (last_ind && last_gene) state_d = StEval;
      StEval:         if (last_ind) state_d = StSelect;
      StSelect:       if (last_ind) state_d = StCross;
      StCross:        state_d = StMutate;
      StMutate:       if (last_gene) state_d = StReplace;
      StReplace:      if (last_ind && side_q) state_d = StCheck;
      StCheck: begin
        if (new_best_fit == FW'(LEN)) state_d = StDone;
        else if (max_gen_q != 16'd0 && gen_inc == max_gen_q) state_d = StDone;
        else state_d = StSelect;
      end
      default:        state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Control counters, parent selection and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ind_q <= '0; gene_q <= '0; side_q <= 1'b0;
      p0_q <= '0; p1_q <= '0; f0_q <= '0; f1_q <= '0; p1_vld_q <= 1'b0;
      worst_q <= '0; worst_f_q <= '0;
      target_q <= '0; thresh_q <= '0; max_gen_q <= '0;
      gen_q <= '0; best_q <= '0; best_fit_q <= '0; success_q <= 1'b0;
    end else begin
      if (start_ok) begin
        target_q <= target_i; thresh_q <= mut_thresh; max_gen_q <= max_gen;
        gen_q <= '0; best_q <= '0; best_fit_q <= '0; success_q <= 1'b0;
        ind_q <= '0; gene_q <= '0; side_q <= 1'b0;
      end
      case (state_q)
        StInit: begin
          if (last_gene) begin
            gene_q <= '0;
            ind_q  <= last_ind ? '0 : ind_q + 1'b1;
          end else begin
            gene_q <= gene_q + 1'b1;
          end
        end
        StEval: ind_q <= last_ind ? '0 : ind_q + 1'b1;
        StSelect: begin
          ind_q <= last_ind ? '0 : ind_q + 1'b1;
          if (ind_q == '0) begin
            p0_q <= ind_q; f0_q <= cur_fit; p1_vld_q <= 1'b0;
          end else if (cur_fit > f0_q) begin
            p1_q <= p0_q; f1_q <= f0_q; p1_vld_q <= 1'b1;
            p0_q <= ind_q; f0_q <= cur_fit;
          end else if (!p1_vld_q || cur_fit > f1_q) begin
            p1_q <= ind_q; f1_q <= cur_fit; p1_vld_q <= 1'b1;
          end
        end
        StMutate: gene_q <= last_gene ? '0 : gene_q + 1'b1;
        StReplace: begin
          worst_q <= wi;
          worst_f_q <= wf;
          if (last_ind) begin
            ind_q  <= '0;
            side_q <= ~side_q;
          end else begin
            ind_q <= ind_q + 1'b1;
          end
        end
        StCheck: begin
          gen_q <= gen_inc;
          if (max_f > best_fit_q) begin
            best_q     <= pop_q[max_i];
            best_fit_q <= max_f;
          end
          if (new_best_fit == FW'(LEN)) success_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Population, fitness table and children; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    case (state_q)
      StInit: pop_q[ind_q][gene_q] <= lfsr_val[GENE_W-1:0];
      StEval: fit_q[ind_q] <= eval_fit;
      StCross: begin
        for (int j = 0; j < LEN; j++) begin
          child0_q[j] <= (32'(j) < cut) ? pop_q[p0_q][j] : pop_q[p1_q][j];
          child1_q[j] <= (32'(j) < cut) ? pop_q[p1_q][j] : pop_q[p0_q][j];
        end
      end
      StMutate: begin
        if (lfsr_val[31:24] < thresh_q) child0_q[gene_q] <= lfsr_val[GENE_W-1:0];
        if (mb1 < thresh_q) child1_q[gene_q] <= rg1;
      end
      StReplace: begin
        if (last_ind && child_fit > wf) begin
          pop_q[wi] <= side_q ? child1_q : child0_q;
          fit_q[wi] <= child_fit;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ga_engine.sv
// Directed bench for ga_engine: reset, success, timeout, determinism, handshake, mid-run reset.
module tb_ga_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [95:0] target, best;
  logic [7:0]  mut;
  logic [15:0] maxg, gen;
  logic        busy, done, success;
  logic [3:0]  bfit;
  logic [6:0]  pct;

  logic        s_start, s_busy, s_done, s_success;
  logic [3:0]  s_target, s_best;
  logic [7:0]  s_mut;
  logic [15:0] s_maxg, s_gen;
  logic [1:0]  s_bfit;
  logic [6:0]  s_pct;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  ga_engine dut (
    .clk(clk), .rst(rst), .start(start), .target_i(target), .mut_thresh(mut), .max_gen(maxg),
    .busy(busy), .done(done), .success(success), .best_o(best), .best_fit(bfit),
    .fitness_percent(pct), .gen_count(gen)
  );

  ga_engine #(.POP(4), .LEN(2), .GENE_W(2)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .target_i(s_target), .mut_thresh(s_mut),
    .max_gen(s_maxg), .busy(s_busy), .done(s_done), .success(s_success), .best_o(s_best),
    .best_fit(s_bfit), .fitness_percent(s_pct), .gen_count(s_gen)
  );

  // best_fit must never drop while a run is in progress.
  logic       prev_busy = 1'b0;
  logic [3:0] prev_bfit = '0;
  int         mono_bad  = 0;
  always @(negedge clk) begin
    if (busy && prev_busy && bfit < prev_bfit) mono_bad++;
    prev_busy = busy;
    prev_bfit = bfit;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_fit(input logic [95:0] a, input logic [95:0] b);
    int n;
    n = 0;
    for (int k = 0; k < 12; k++) if (a[k*8 +: 8] == b[k*8 +: 8]) n++;
    return n;
  endfunction

  // Starts a run from a negedge and follows it to done; optional ignored start poke or reset.
  task automatic run_big(input logic [95:0] tgt, input logic [7:0] mt, input logic [15:0] mg,
                         input int poke_at, input int rst_at, output int cyc);
    int n;
    target = tgt; mut = mt; maxg = mg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_begins_run", {busy, done}, 2'b10);
    cyc = 0;
    n = 0;
    while (!done && n < 5000) begin
      if (busy) cyc++;
      if (n == rst_at) begin
        check("gen_before_rst", gen, 16'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_busy", {busy, done, success}, 3'b000);
        check("rst_async_gen", gen, 16'd0);
        check("rst_async_best", {best, bfit, pct}, '0);
        @(negedge clk);
        rst = 1'b0;
        cyc = -1;
        return;
      end
      if (n == poke_at) begin
        start = 1'b1;
        target = ~tgt;
      end
      @(negedge clk);
      start = 1'b0;
      target = tgt;
      n++;
    end
    check("run_finished", done, 1'b1);
  endtask

  initial begin
    int n, cyc_a, cyc;
    logic [95:0] best_a, tgt_h, tgt_d;
    logic [15:0] gen_a;

    rst = 1'b1; start = 1'b0; target = '0; mut = '0; maxg = '0;
    s_start = 1'b0; s_target = '0; s_mut = '0; s_maxg = '0;
    tgt_h = 96'("Hello World!");
    tgt_d = 96'h0123_4567_89AB_CDEF_5A5A_C3C3;

    // Reset state.
    @(negedge clk);
    check("rst_flags", {busy, done, success}, 3'b000);
    check("rst_gen", gen, 16'd0);
    check("rst_fit", {bfit, pct}, '0);
    check("rst_small", {s_busy, s_done, s_success, s_bfit, s_pct, s_gen}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Small engine reaches its target.
    s_target = 4'b1001; s_mut = 8'd64; s_maxg = 16'd0; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n = 0;
    while (!s_done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("small_done", {s_done, s_busy, s_success}, 3'b101);
    check("small_best", s_best, 4'b1001);
    check("small_fit", s_bfit, 2'd2);
    check("small_pct", s_pct, 7'd100);

    // Timeout after three generations without mutation.
    run_big(tgt_h, 8'd0, 16'd3, -1, -1, cyc);
    check("to_cycles", cyc, 218);
    check("to_gen", gen, 16'd3);
    check("to_success", success, 1'b0);
    check("to_fit_model", bfit, 4'(model_fit(best, tgt_h)));
    check("to_pct", pct, 7'(model_fit(best, tgt_h) * 100 / 12));

    // Determinism: identical inputs give identical results.
    run_big(tgt_d, 8'd40, 16'd5, -1, -1, cyc_a);
    gen_a = gen;
    best_a = best;
    check("det_cycles", cyc_a, 294);
    check("det_gen", gen_a, 16'd5);
    check("det_fit_model", bfit, 4'(model_fit(best_a, tgt_d)));
    run_big(tgt_d, 8'd40, 16'd5, -1, -1, cyc);
    check("rep_cycles", cyc, cyc_a);
    check("rep_gen", gen, gen_a);
    check("rep_best", best, best_a);

    // start while busy is ignored, even with a different target on the bus.
    run_big(tgt_d, 8'd40, 16'd5, 50, -1, cyc);
    check("poke_cycles", cyc, cyc_a);
    check("poke_best", best, best_a);
    check("poke_gen", gen, gen_a);

    // Reset in the second generation's mutate phase, then a clean rerun.
    run_big(tgt_d, 8'd40, 16'd5, -1, 155, cyc);
    run_big(tgt_d, 8'd40, 16'd5, -1, -1, cyc);
    check("rerun_cycles", cyc, cyc_a);
    check("rerun_best", best, best_a);
    check("rerun_gen", gen, gen_a);

    check("best_fit_monotonic", mono_bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
